match_sequencer: RTL

- Single-clock controller that sequences the volleyball scoreboard's two 5-bit point counters through a full match.
- Accepts debounced one-cycle button pulses (point A, point B, undo, next), owns both point registers and set tallies, and applies the set-win rule.
  - 25 points with a 2-point lead in sets 1-4; 15 in set 5.
- Drives the display/decoder layer and the mode25_15 indicator.
- Replaces the dual-button-clock counter pair with a synchronous scheduler.

---
 rtl/match_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/match_sequencer.sv
// -----------------------------------------------------------------------------
// match_sequencer
//   Single-clock volleyball match controller. It owns both point counters and
//   both set tallies, and applies the set-win rule. The target is SET_PTS with
//   a 2-point lead in the ordinary sets and TB_PTS in the deciding set. A
//   counter that reaches its saturation value always wins the set, so it can
//   never wrap. A one-level history lets the operator revert the last awarded
//   point, including a point that closed a set or the match.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   synchronous reset, active-low
//   pt_a/pt_b  in   one-cycle pulse: point to team A / team B
//   undo       in   one-cycle pulse: revert the last awarded point
//   next       in   one-cycle pulse: start match / advance set / clear match
//   pnt1/pnt2  out  team A / team B points
//   set1/set2  out  team A / team B sets won
//   set_num    out  current set 1..2*SETS_TO_WIN-1 (0 while idle)
//   serve      out  0 = team A serving, 1 = team B serving
//   mode25_15  out  1 = ordinary set target, 0 = deciding set target
//   RCOpnt1/2  out  one-cycle pulse: team A / team B won the set
//   match_over out  high while the match is finished
//   state      out  00 IDLE, 01 PLAY, 10 SET_END, 11 MATCH_END
// -----------------------------------------------------------------------------
module match_sequencer #(
  parameter int unsigned SET_PTS     = 25,
  parameter int unsigned TB_PTS      = 15,
  parameter int unsigned SETS_TO_WIN = 3,
  parameter int unsigned PNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pt_a,
  input  logic             pt_b,
  input  logic             undo,
  input  logic             next,
  output logic [PNT_W-1:0] pnt1,
  output logic [PNT_W-1:0] pnt2,
  output logic [1:0]       set1,
  output logic [1:0]       set2,
  output logic [2:0]       set_num,
  output logic             serve,
  output logic             mode25_15,
  output logic             RCOpnt1,
  output logic             RCOpnt2,
  output logic             match_over,
  output logic [1:0]       state
);

  localparam int unsigned      LAST_SET_I = 2 * SETS_TO_WIN - 1;
  localparam logic [2:0]       LAST_SET   = LAST_SET_I[2:0];
  localparam logic [1:0]       SETS_WIN   = SETS_TO_WIN[1:0];
  localparam logic [PNT_W-1:0] PNT_MAX    = '1;
  localparam logic [PNT_W:0]   SET_T      = SET_PTS[PNT_W:0];
  localparam logic [PNT_W:0]   TB_T       = TB_PTS[PNT_W:0];
  localparam logic [PNT_W:0]   LEAD       = (PNT_W + 1)'(2);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    SET_END   = 2'b10,
    MATCH_END = 2'b11
  } state_t;

  state_t st;

  // One-level undo history
  logic [PNT_W-1:0] h_pnt1;
  logic [PNT_W-1:0] h_pnt2;
  logic             h_serve;
  logic             h_valid;

  // Point-award helpers
  logic [PNT_W:0]   target;
  logic [PNT_W-1:0] a_inc;
  logic [PNT_W-1:0] b_inc;
  logic             a_win;
  logic             b_win;
  logic [1:0]       set1_inc;
  logic [1:0]       set2_inc;
  logic [2:0]       set_num_inc;
  logic             one_point;

  always_comb begin
    target      = (set_num == LAST_SET) ? TB_T : SET_T;
    a_inc       = (pnt1 == PNT_MAX) ? pnt1 : pnt1 + 1'b1;
    b_inc       = (pnt2 == PNT_MAX) ? pnt2 : pnt2 + 1'b1;
    // Lead test is done one bit wider so that "v - o >= 2" cannot underflow.
    a_win       = (({1'b0, a_inc} >= target) && ({1'b0, a_inc} >= {1'b0, pnt2} + LEAD))
                  || (a_inc == PNT_MAX);
    b_win       = (({1'b0, b_inc} >= target) && ({1'b0, b_inc} >= {1'b0, pnt1} + LEAD))
                  || (b_inc == PNT_MAX);
    set1_inc    = set1 + 2'd1;
    set2_inc    = set2 + 2'd1;
    set_num_inc = set_num + 3'd1;
    one_point   = pt_a ^ pt_b;
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= IDLE;
      pnt1       <= '0;
      pnt2       <= '0;
      set1       <= '0;
      set2       <= '0;
      set_num    <= '0;
      serve      <= 1'b0;
      mode25_15  <= 1'b1;
      RCOpnt1    <= 1'b0;
      RCOpnt2    <= 1'b0;
      match_over <= 1'b0;
      h_pnt1     <= '0;
      h_pnt2     <= '0;
      h_serve    <= 1'b0;
      h_valid    <= 1'b0;
    end else begin
      RCOpnt1 <= 1'b0;
      RCOpnt2 <= 1'b0;

      // Strict priority: the highest asserted pulse owns the cycle, even
      // when it is not valid in the current state; lower pulses are dropped.
      if (undo) begin
        if (h_valid && (st != IDLE)) begin
          pnt1    <= h_pnt1;
          pnt2    <= h_pnt2;
          serve   <= h_serve;
          h_valid <= 1'b0;
          if ((st == SET_END) || (st == MATCH_END)) begin
            // The set winner scored the last point, so it is the server.
            if (serve) set2 <= set2 - 2'd1;
            else       set1 <= set1 - 2'd1;
            st         <= PLAY;
            match_over <= 1'b0;
          end
        end
      end else if (next) begin
        unique case (st)
          IDLE: begin
            st        <= PLAY;
            set_num   <= 3'd1;
            pnt1      <= '0;
            pnt2      <= '0;
            serve     <= 1'b0;
            mode25_15 <= 1'b1;
            h_valid   <= 1'b0;
          end
          SET_END: begin
            st        <= PLAY;
            set_num   <= set_num_inc;
            pnt1      <= '0;
            pnt2      <= '0;
            serve     <= ~set_num_inc[0];
            mode25_15 <= (set_num_inc != LAST_SET);
            h_valid   <= 1'b0;
          end
          MATCH_END: begin
            st         <= IDLE;
            pnt1       <= '0;
            pnt2       <= '0;
            set1       <= '0;
            set2       <= '0;
            set_num    <= '0;
            serve      <= 1'b0;
            mode25_15  <= 1'b1;
            match_over <= 1'b0;
            h_valid    <= 1'b0;
          end
          default: ;
        endcase
      end else if (one_point && (st == PLAY)) begin
        h_pnt1  <= pnt1;
        h_pnt2  <= pnt2;
        h_serve <= serve;
        h_valid <= 1'b1;
        if (pt_a) begin
          pnt1  <= a_inc;
          serve <= 1'b0;
          if (a_win) begin
            set1    <= set1_inc;
            RCOpnt1 <= 1'b1;
            if (set1_inc == SETS_WIN) begin
              st         <= MATCH_END;
              match_over <= 1'b1;
            end else begin
              st <= SET_END;
            end
          end
        end else begin
          pnt2  <= b_inc;
          serve <= 1'b1;
          if (b_win) begin
            set2    <= set2_inc;
            RCOpnt2 <= 1'b1;
            if (set2_inc == SETS_WIN) begin
              st         <= MATCH_END;
              match_over <= 1'b1;
            end else begin
              st <= SET_END;
            end
          end
        end
      end
    end
  end

endmodule
